// File: rtl/rgb_pkg.sv
// rtl/rgb_pkg.sv - palette codes, colour lookup and gamma helper for rgb_pwm_array
package rgb_pkg;

    localparam logic [3:0] C_MAROON = 4'd0;
    localparam logic [3:0] C_RED    = 4'd1;
    localparam logic [3:0] C_ORANGE = 4'd2;
    localparam logic [3:0] C_YELLOW = 4'd3;
    localparam logic [3:0] C_GREEN  = 4'd4;
    localparam logic [3:0] C_LIME   = 4'd5;
    localparam logic [3:0] C_TEAL   = 4'd6;
    localparam logic [3:0] C_CYAN   = 4'd7;
    localparam logic [3:0] C_BLUE   = 4'd8;
    localparam logic [3:0] C_PURPLE = 4'd9;
    localparam logic [3:0] C_VIOLET = 4'd10;
    localparam logic [3:0] C_SIENNA = 4'd11;
    localparam logic [3:0] C_SILVER = 4'd12;
    localparam logic [3:0] C_OFF    = 4'd13;

    function automatic logic [23:0] color_to_rgb(input logic [3:0] code);
        case (code)
            C_MAROON: return 24'h800000;
            C_RED:    return 24'hFF0000;
            C_ORANGE: return 24'hFFA500;
            C_YELLOW: return 24'hFFFF00;
            C_GREEN:  return 24'h008000;
            C_LIME:   return 24'h00FF00;
            C_TEAL:   return 24'h008080;
            C_CYAN:   return 24'h00FFFF;
            C_BLUE:   return 24'h0000FF;
            C_PURPLE: return 24'h800080;
            C_VIOLET: return 24'hEE82EE;
            C_SIENNA: return 24'hA0522D;
            C_SILVER: return 24'hC0C0C0;
            default:  return 24'h000000;
        endcase
    endfunction

    // Square-law duty: (d*d) >> w, d already left-aligned to w bits.
    function automatic logic [11:0] gamma_duty(input logic [11:0] d, input int w);
        logic [23:0] sq;
        sq = 24'(d) * 24'(d);
        sq = sq >> w;
        return sq[11:0];
    endfunction

endpackage

// File: rtl/rgb_pwm_chan.sv
// rtl/rgb_pwm_chan.sv - one RGB LED: committed colour/blink, duty decode, compare (RGB_GAMMA_EN selects gamma duty)
module rgb_pwm_chan #(
    parameter int PWM_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             wr,
    input  logic [3:0]       wr_color,
    input  logic             wr_blink,
    input  logic [PWM_W-1:0] pwm_ctr,
    input  logic             blink_phase,
    output logic             r,
    output logic             g,
    output logic             b
);
    import rgb_pkg::*;

    logic [3:0]       color;
    logic [3:0]       eff_color;
    logic             blink;
    logic             eff_blink;
    logic [23:0]      rgb;
    logic [PWM_W-1:0] duty_r;
    logic [PWM_W-1:0] duty_g;
    logic [PWM_W-1:0] duty_b;
    logic             lit;

    function automatic logic [PWM_W-1:0] duty_of(input logic [7:0] v);
        logic [PWM_W-1:0] d;
        d = PWM_W'(v) << (PWM_W - 8);
`ifdef RGB_GAMMA_EN
        return PWM_W'(gamma_duty(12'(d), PWM_W));
`else
        return d;
`endif
    endfunction

    // A commit bypasses into the compare so the boundary slot already uses the new colour.
    always_comb begin
        eff_color = wr ? wr_color : color;
        eff_blink = wr ? wr_blink : blink;
        rgb       = color_to_rgb(eff_color);
        duty_r    = duty_of(rgb[23:16]);
        duty_g    = duty_of(rgb[15:8]);
        duty_b    = duty_of(rgb[7:0]);
        lit       = en && !(eff_blink && blink_phase);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            color <= C_OFF;
            blink <= 1'b0;
            r     <= 1'b0;
            g     <= 1'b0;
            b     <= 1'b0;
        end else begin
            if (wr) begin
                color <= wr_color;
                blink <= wr_blink;
            end
            r <= lit && (pwm_ctr < duty_r);
            g <= lit && (pwm_ctr < duty_g);
            b <= lit && (pwm_ctr < duty_b);
        end
    end

endmodule

// File: rtl/rgb_pwm_array.sv
// rtl/rgb_pwm_array.sv - multi-LED RGB PWM driver with boundary-synchronous colour commits (RGB_GAMMA_EN optional)
module rgb_pwm_array #(
    parameter int NUM_LED       = 4,
    parameter int PWM_W         = 8,
    parameter int PWM_DIV       = 1,
    parameter int BLINK_PERIODS = 2,
    localparam int LED_W        = (NUM_LED > 1) ? $clog2(NUM_LED) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               sel_valid,
    output logic               sel_ready,
    input  logic [LED_W-1:0]   sel_led,
    input  logic [3:0]         sel_color,
    input  logic               sel_blink,
    output logic [NUM_LED-1:0] r_out,
    output logic [NUM_LED-1:0] g_out,
    output logic [NUM_LED-1:0] b_out,
    output logic               period_start
);
    import rgb_pkg::*;

    localparam int DIV_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam int BLK_W = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
    localparam logic [PWM_W-1:0] CTR_MAX = '1;

    logic [DIV_W-1:0] div_ctr;
    logic [PWM_W-1:0] pwm_ctr;
    logic [BLK_W-1:0] blink_ctr;
    logic             blink_phase;
    logic             tick;
    logic             wrap;
    logic             pending;
    logic [LED_W-1:0] pend_led;
    logic [3:0]       pend_color;
    logic             pend_blink;
    logic             commit;

    assign tick      = en && (div_ctr == DIV_W'(PWM_DIV - 1));
    assign wrap      = tick && (pwm_ctr == CTR_MAX);
    assign sel_ready = !pending;
    // With the PWM stopped there is no boundary to wait for, so commit straight away.
    assign commit    = pending && (!en || period_start);

    // Blink phase flips on the wrap itself so it is already valid in the period_start slot.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            div_ctr      <= '0;
            pwm_ctr      <= '0;
            blink_ctr    <= '0;
            blink_phase  <= 1'b0;
            period_start <= 1'b0;
        end else begin
            div_ctr      <= tick ? '0 : div_ctr + 1'b1;
            period_start <= wrap;
            if (tick) begin
                pwm_ctr <= pwm_ctr + 1'b1;
            end
            if (wrap) begin
                if (blink_ctr == BLK_W'(BLINK_PERIODS - 1)) begin
                    blink_ctr   <= '0;
                    blink_phase <= !blink_phase;
                end else begin
                    blink_ctr <= blink_ctr + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending    <= 1'b0;
            pend_led   <= '0;
            pend_color <= C_OFF;
            pend_blink <= 1'b0;
        end else if (sel_valid && sel_ready) begin
            pending    <= 1'b1;
            pend_led   <= sel_led;
            pend_color <= sel_color;
            pend_blink <= sel_blink;
        end else if (commit) begin
            pending <= 1'b0;
        end
    end

    // Out-of-range targets match no channel and simply drain from the slot.
    for (genvar i = 0; i < NUM_LED; i++) begin : g_led
        rgb_pwm_chan #(
            .PWM_W(PWM_W)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .en         (en),
            .wr         (commit && (pend_led == LED_W'(i))),
            .wr_color   (pend_color),
            .wr_blink   (pend_blink),
            .pwm_ctr    (pwm_ctr),
            .blink_phase(blink_phase),
            .r          (r_out[i]),
            .g          (g_out[i]),
            .b          (b_out[i])
        );
    end

endmodule

// File: doc/rgb_pwm_array.md
# rgb_pwm_array

Parametrised multi-LED RGB PWM driver, successor to the single-LED colour driver in the board-I/O layer. It drives NUM_LED tri-colour LEDs from a shared 14-entry named-colour palette, with per-LED solid/blink mode and glitch-free colour updates committed only at PWM period boundaries. Colour changes arrive through a valid/ready request port from the menu/button controller.

## Interface
Parameters:
- NUM_LED, 4: number of RGB LEDs driven (1..16).
- PWM_W, 8: PWM counter/duty width (8..12); palette bytes are left-aligned, duty = {byte, (PWM_W-8) zeros}.
- PWM_DIV, 1: clock cycles per PWM counter step (1..2^16).
- BLINK_PERIODS, 2: PWM periods per blink half-phase (1..2^20).

Ports:
- clk, in, 1: system clock.
- rst, in, 1: reset, synchronous, active-high.
- en, in, 1: global enable; low forces all LEDs dark.
- sel_valid, in, 1: colour request valid.
- sel_ready, out, 1: request slot free.
- sel_led, in, clog2(NUM_LED) (min 1): target LED index.
- sel_color, in, 4: palette code.
- sel_blink, in, 1: 1 = blink mode, 0 = solid.
- r_out / g_out / b_out, out, NUM_LED each: registered PWM outputs, bit i = LED i.
- period_start, out, 1: one-cycle pulse when the PWM counter wraps to 0.

## Operation
- Palette codes (R,G,B): 0 maroon 128,0,0; 1 red 255,0,0; 2 orange 255,165,0; 3 yellow 255,255,0; 4 green 0,128,0; 5 lime 0,255,0; 6 teal 0,128,128; 7 cyan 0,255,255; 8 blue 0,0,255; 9 purple 128,0,128; 10 violet 238,130,238; 11 sienna 160,82,45; 12 silver 192,192,192; 13–15 off 0,0,0.
- Per LED: committed color[3:0], blink bit. Reset: color = 13, blink = 0.
- Handshake: transfer when sel_valid && sel_ready; request captured into a single pending slot; sel_ready = !pending. sel_led >= NUM_LED: request accepted and discarded.
- Commit: en high → pending written to target LED on the cycle period_start is asserted; en low → committed on the cycle after acceptance. pending clears on commit; sel_ready high the next cycle.
- PWM: tick every PWM_DIV cycles; pwm_ctr (PWM_W bits) increments on tick, wraps 2^PWM_W-1 → 0. Channel output high iff pwm_ctr < duty; duty 0 = always low; max byte 255 at PWM_W=8 → 255/256 duty.
- Blink: blink_ctr counts period_start pulses; after BLINK_PERIODS, blink_ctr → 0 and blink_phase toggles. Phase shared by all LEDs (synchronised). LED with blink = 1 is forced dark while blink_phase = 1. Reset phase = 0 (lit).
- en low: outputs 0, pwm_ctr, divider, blink_ctr, blink_phase held at 0; committed colours retained. en rising: PWM restarts from 0, first period_start on the first wrap.

## Timing
- Outputs registered: value at cycle t+1 reflects pwm_ctr/duty/phase at cycle t. All outputs 0 during and one cycle after reset.
- period_start registered, coincident with pwm_ctr = 0 in the cycle after the wrap tick.
- Accept-to-visible latency with en high: commit at next period_start, outputs change the following cycle; never mid-period.
- Simultaneous accept and period_start: the newly accepted request waits for the next boundary.
- rst mid-operation: pending discarded, all state to reset values in one cycle.

## Configuration
- RGB_GAMMA_EN defined: duty = (d*d) >> PWM_W with d = left-aligned palette value (128 at PWM_W=8 → 64; 255 → 254). Undefined: linear duty = d. Palette, handshake and timing unchanged.

## Structure
- Package rgb_pkg: colour code localparams (C_MAROON..C_OFF), palette function color_to_rgb(code) returning 24-bit {R,G,B}, gamma function.
- Sub-module rgb_pwm_chan: one instance per LED; holds color/blink registers, duty decode, compare and output registers. Top holds divider, pwm_ctr, blink logic, handshake.

## Test plan
- Reset, en=1, PWM_W=8, PWM_DIV=1 → all outputs 0; period_start every 256 cycles; sel_ready=1.
- Request LED1 red solid mid-period → sel_ready low until commit; r_out[1] starts at the next period, high 255/256 cycles, g/b low; other LEDs unaffected.
- LED0 orange, blink, BLINK_PERIODS=2 → 512 cycles with r high 255/256 and g high 165/256, then 512 dark, repeating.
- en low with requests issued → outputs stay 0; commit on the cycle after accept; en high → new colour from first period.
- Back-to-back valid with sel_led=NUM_LED → accepted, no LED changes; second request stalls until the boundary.
- RGB_GAMMA_EN build, maroon → r_out high exactly 64 of 256 cycles.
